// File: rtl/md_pkg.sv
// md_pkg: shared types and helpers for the multiply/divide unit.
// Holds the md_op_t encoding, the op-width constant and the helpers that
// classify ops and give their busy latency.
// MDU_MADD_EN: when defined, MADD/MADDU/MSUB/MSUBU are multi-cycle ops;
// otherwise their codes behave as NONE.
package md_pkg;

    localparam int unsigned MD_OP_W   = 4;
    localparam int unsigned MD_DATA_W = 32;

    typedef enum logic [MD_OP_W-1:0] {
        MD_NONE  = 4'd0,
        MD_MULT  = 4'd1,
        MD_MULTU = 4'd2,
        MD_DIV   = 4'd3,
        MD_DIVU  = 4'd4,
        MD_MFHI  = 4'd5,
        MD_MFLO  = 4'd6,
        MD_MTHI  = 4'd7,
        MD_MTLO  = 4'd8,
        MD_MADD  = 4'd9,
        MD_MADDU = 4'd10,
        MD_MSUB  = 4'd11,
        MD_MSUBU = 4'd12
    } md_op_t;

    // Ops that load the counter and later commit the shadow result.
    function automatic logic is_md_busy_op(input md_op_t op);
        logic r;
        case (op)
            MD_MULT, MD_MULTU, MD_DIV, MD_DIVU: r = 1'b1;
`ifdef MDU_MADD_EN
            MD_MADD, MD_MADDU, MD_MSUB, MD_MSUBU: r = 1'b1;
`endif
            default: r = 1'b0;
        endcase
        return r;
    endfunction

    // Busy latency: divides take the divide count, every other busy op the multiply count.
    function automatic int unsigned op_latency(input md_op_t op,
                                               input int unsigned mult_cycles,
                                               input int unsigned div_cycles);
        int unsigned r;
        case (op)
            MD_DIV, MD_DIVU: r = div_cycles;
            default:         r = mult_cycles;
        endcase
        return r;
    endfunction

endpackage

// File: rtl/md_arith.sv
// md_arith: combinational 64-bit result generator for the MD unit.
// Ports:
//   op       in   operation code (md_op_t)
//   rs, rt   in   32-bit operands
//   hi, lo   in   current HI/LO (accumulate base for the madd family)
//   result_c out  {HI,LO} result to latch into the shadow registers
//   wr_c     out  result is to be committed (low for divide by zero)
// MDU_MADD_EN: enables the accumulate/subtract variants.
module md_arith
    import md_pkg::*;
(
    input  md_op_t                op,
    input  logic [MD_DATA_W-1:0]  rs,
    input  logic [MD_DATA_W-1:0]  rt,
    input  logic [MD_DATA_W-1:0]  hi,
    input  logic [MD_DATA_W-1:0]  lo,
    output logic [2*MD_DATA_W-1:0] result_c,
    output logic                  wr_c
);

    logic                   mul_signed;
    logic [2*MD_DATA_W-1:0] ext_a;
    logic [2*MD_DATA_W-1:0] ext_b;
    logic [2*MD_DATA_W-1:0] prod;

    logic                 div_signed;
    logic                 a_neg;
    logic                 b_neg;
    logic [MD_DATA_W-1:0] a_mag;
    logic [MD_DATA_W-1:0] b_mag;
    logic [MD_DATA_W-1:0] q_mag;
    logic [MD_DATA_W-1:0] r_mag;
    logic [MD_DATA_W-1:0] quot;
    logic [MD_DATA_W-1:0] rem;

    // Sign-extend to 64 bits so one truncated unsigned multiply serves both signednesses.
    always_comb begin
        mul_signed = (op == MD_MULT) || (op == MD_MADD) || (op == MD_MSUB);
        ext_a = mul_signed ? {{MD_DATA_W{rs[MD_DATA_W-1]}}, rs} : {{MD_DATA_W{1'b0}}, rs};
        ext_b = mul_signed ? {{MD_DATA_W{rt[MD_DATA_W-1]}}, rt} : {{MD_DATA_W{1'b0}}, rt};
        prod  = ext_a * ext_b;
    end

    // Signed divide via magnitudes: quotient truncates toward 0, remainder follows the dividend.
    // 0x80000000 / -1 falls out as 0x80000000 with remainder 0.
    always_comb begin
        div_signed = (op == MD_DIV);
        a_neg = div_signed & rs[MD_DATA_W-1];
        b_neg = div_signed & rt[MD_DATA_W-1];
        a_mag = a_neg ? (MD_DATA_W'(0) - rs) : rs;
        b_mag = b_neg ? (MD_DATA_W'(0) - rt) : rt;
        if (b_mag == '0) begin
            b_mag = MD_DATA_W'(1);
        end
        q_mag = a_mag / b_mag;
        r_mag = a_mag % b_mag;
        quot  = (a_neg ^ b_neg) ? (MD_DATA_W'(0) - q_mag) : q_mag;
        rem   = a_neg ? (MD_DATA_W'(0) - r_mag) : r_mag;
    end

    always_comb begin
        result_c = prod;
        wr_c     = 1'b1;
        case (op)
            MD_DIV, MD_DIVU: begin
                result_c = {rem, quot};
                wr_c     = (rt != '0);
            end
`ifdef MDU_MADD_EN
            MD_MADD, MD_MADDU: result_c = {hi, lo} + prod;
            MD_MSUB, MD_MSUBU: result_c = {hi, lo} - prod;
`endif
            default: result_c = prod;
        endcase
    end

`ifndef MDU_MADD_EN
    // The accumulate base is only consumed by the madd family.
    logic unused_acc;
    assign unused_acc = ^{hi, lo};
`endif

endmodule

// File: rtl/md_unit.sv
// md_unit: E-stage multiply/divide unit; owns HI/LO.
// Ports:
//   clk, reset   clock and synchronous active-high reset
//   start, md_op E-stage MD instruction and its operation code
//   req          interrupt/exception this cycle; blocks acceptance
//   rs_val       forwarded GPR[rs]; rt_val forwarded GPR[rt]
//   busy         multi-cycle op in flight (cnt != 0)
//   hi_out       architectural HI; lo_out architectural LO
//   md_out       HI for MFHI, LO for MFLO, else 0 (combinational from md_op)
// MDU_MADD_EN: when defined, adds MADD/MADDU/MSUB/MSUBU with MULT_CYCLES latency.
module md_unit
    import md_pkg::*;
#(
    parameter int unsigned MULT_CYCLES = 5,
    parameter int unsigned DIV_CYCLES  = 10
) (
    input  logic                 clk,
    input  logic                 reset,
    input  logic                 start,
    input  logic [MD_OP_W-1:0]   md_op,
    input  logic                 req,
    input  logic [MD_DATA_W-1:0] rs_val,
    input  logic [MD_DATA_W-1:0] rt_val,
    output logic                 busy,
    output logic [MD_DATA_W-1:0] hi_out,
    output logic [MD_DATA_W-1:0] lo_out,
    output logic [MD_DATA_W-1:0] md_out
);

    localparam int unsigned MAX_CYCLES = (MULT_CYCLES > DIV_CYCLES) ? MULT_CYCLES : DIV_CYCLES;
    localparam int unsigned CNT_W      = $clog2(MAX_CYCLES + 1);

    md_op_t                 op;
    logic [CNT_W-1:0]       cnt;
    logic [MD_DATA_W-1:0]   hi_q;
    logic [MD_DATA_W-1:0]   lo_q;
    logic [2*MD_DATA_W-1:0] shadow_q;
    logic                   shadow_wr_q;

    logic [2*MD_DATA_W-1:0] arith_res;
    logic                   arith_wr;
    logic                   issue_ok;
    logic                   accept;
    logic                   write_hi;
    logic                   write_lo;
    logic                   commit;

    assign op       = md_op_t'(md_op);
    assign busy     = (cnt != '0);
    assign issue_ok = start && !req && !busy;
    assign accept   = issue_ok && is_md_busy_op(op);
    assign write_hi = issue_ok && (op == MD_MTHI);
    assign write_lo = issue_ok && (op == MD_MTLO);
    assign commit   = (cnt == CNT_W'(1)) && shadow_wr_q;

    md_arith u_arith (
        .op       (op),
        .rs       (rs_val),
        .rt       (rt_val),
        .hi       (hi_q),
        .lo       (lo_q),
        .result_c (arith_res),
        .wr_c     (arith_wr)
    );

    // Counter and shadow result: loaded on accept, counted down while busy.
    always_ff @(posedge clk) begin
        if (reset) begin
            cnt         <= '0;
            shadow_q    <= '0;
            shadow_wr_q <= 1'b0;
        end else if (accept) begin
            cnt         <= CNT_W'(op_latency(op, MULT_CYCLES, DIV_CYCLES));
            shadow_q    <= arith_res;
            shadow_wr_q <= arith_wr;
        end else if (busy) begin
            cnt <= cnt - CNT_W'(1);
        end
    end

    // HI/LO: commit of a finished op, or a direct move (only possible while idle).
    always_ff @(posedge clk) begin
        if (reset) begin
            hi_q <= '0;
            lo_q <= '0;
        end else if (commit) begin
            hi_q <= shadow_q[2*MD_DATA_W-1:MD_DATA_W];
            lo_q <= shadow_q[MD_DATA_W-1:0];
        end else begin
            if (write_hi) begin
                hi_q <= rs_val;
            end
            if (write_lo) begin
                lo_q <= rs_val;
            end
        end
    end

    // The hazard unit should never let an MD instruction reach E while busy.
    always_ff @(posedge clk) begin
        if (!reset) begin
            assert (!(start && !req && busy && (op != MD_NONE)))
                else $warning("md_unit: MD instruction issued while busy; ignored");
        end
    end

    assign hi_out = hi_q;
    assign lo_out = lo_q;

    always_comb begin
        md_out = '0;
        case (op)
            MD_MFHI: md_out = hi_q;
            MD_MFLO: md_out = lo_q;
            default: md_out = '0;
        endcase
    end

endmodule

// File: tb/tb_md_unit.sv
module tb_md_unit;
    import md_pkg::*;

    localparam int MULT_N = 5;
    localparam int DIV_N  = 10;

    logic        clk = 1'b0;
    logic        reset = 1'b1;
    logic        start = 1'b0;
    logic [3:0]  md_op = 4'd0;
    logic        req = 1'b0;
    logic [31:0] rs_val = '0;
    logic [31:0] rt_val = '0;
    logic        busy;
    logic [31:0] hi_out;
    logic [31:0] lo_out;
    logic [31:0] md_out;

    int checks = 0;
    int errors = 0;

    // Reference architectural state
    logic [31:0] m_hi = '0;
    logic [31:0] m_lo = '0;

    md_unit #(.MULT_CYCLES(MULT_N), .DIV_CYCLES(DIV_N)) dut (
        .clk    (clk),
        .reset  (reset),
        .start  (start),
        .md_op  (md_op),
        .req    (req),
        .rs_val (rs_val),
        .rt_val (rt_val),
        .busy   (busy),
        .hi_out (hi_out),
        .lo_out (lo_out),
        .md_out (md_out)
    );

    always #5 clk = ~clk;

    // Architectural effect of one op on {HI,LO}, straight from the ISA definition.
    task automatic model(input md_op_t op, input logic [31:0] a, input logic [31:0] b,
                         inout logic [31:0] hi, inout logic [31:0] lo);
        longint sa, sb, q, r;
        logic [63:0] p, acc;
        sa = longint'($signed(a));
        sb = longint'($signed(b));
        acc = {hi, lo};
        case (op)
            MD_MULT:  begin p = 64'(sa * sb); {hi, lo} = p; end
            MD_MULTU: begin p = {32'd0, a} * {32'd0, b}; {hi, lo} = p; end
            MD_DIV: if (b != 0) begin
                q = sa / sb; r = sa % sb;
                lo = q[31:0]; hi = r[31:0];
            end
            MD_DIVU: if (b != 0) begin lo = a / b; hi = a % b; end
            MD_MTHI: hi = a;
            MD_MTLO: lo = a;
`ifdef MDU_MADD_EN
            MD_MADD:  begin p = 64'(sa * sb); {hi, lo} = acc + p; end
            MD_MADDU: begin p = {32'd0, a} * {32'd0, b}; {hi, lo} = acc + p; end
            MD_MSUB:  begin p = 64'(sa * sb); {hi, lo} = acc - p; end
            MD_MSUBU: begin p = {32'd0, a} * {32'd0, b}; {hi, lo} = acc - p; end
`endif
            default: ;
        endcase
    endtask

    function automatic int exp_busy(input md_op_t op);
        case (op)
            MD_MULT, MD_MULTU: return MULT_N;
            MD_DIV, MD_DIVU:   return DIV_N;
`ifdef MDU_MADD_EN
            MD_MADD, MD_MADDU, MD_MSUB, MD_MSUBU: return MULT_N;
`endif
            default: return 0;
        endcase
    endfunction

    // Issue one op (called #1 after an edge), then count busy cycles until idle.
    // held reports whether HI/LO kept their pre-issue values for the whole busy window.
    task automatic do_op(input md_op_t op, input logic [31:0] a, input logic [31:0] b,
                         output int cycles, output bit held);
        logic [31:0] h0, l0;
        h0 = hi_out; l0 = lo_out;
        start = 1'b1; md_op = op; rs_val = a; rt_val = b; req = 1'b0;
        @(posedge clk); #1;
        start = 1'b0; md_op = MD_NONE;
        cycles = 0; held = 1'b1;
        while (busy && cycles < 200) begin
            cycles++;
            if (hi_out !== h0 || lo_out !== l0) held = 1'b0;
            @(posedge clk); #1;
        end
    endtask

    task automatic set_hilo(input logic [31:0] h, input logic [31:0] l);
        int c; bit hd;
        do_op(MD_MTHI, h, 32'd0, c, hd);
        do_op(MD_MTLO, l, 32'd0, c, hd);
        model(MD_MTHI, h, 32'd0, m_hi, m_lo);
        model(MD_MTLO, l, 32'd0, m_hi, m_lo);
    endtask

    task automatic test_reset;
        reset = 1'b1;
        repeat (2) @(posedge clk);
        #1; reset = 1'b0;
        m_hi = '0; m_lo = '0;
        md_op = MD_MFHI; #1;
        checks++;
        if (busy !== 1'b0 || hi_out !== 32'd0 || lo_out !== 32'd0 || md_out !== 32'd0) begin
            errors++;
            $display("FAIL reset: busy=%b hi=%h lo=%h md_out=%h want 0/0/0/0", busy, hi_out, lo_out, md_out);
        end
        md_op = MD_NONE;
    endtask

    task automatic test_mult;
        int c; bit hd;
        set_hilo(32'hAAAA_0000, 32'h0000_5555);
        do_op(MD_MULT, 32'hFFFF_FFFF, 32'd2, c, hd);
        checks++;
        if (c !== MULT_N) begin errors++; $display("FAIL mult_busy: got %0d want %0d", c, MULT_N); end
        checks++;
        if (!hd) begin errors++; $display("FAIL mult_hold: HI/LO changed while busy"); end
        checks++;
        if (hi_out !== 32'hFFFF_FFFF || lo_out !== 32'hFFFF_FFFE) begin
            errors++; $display("FAIL mult_result: hi=%h lo=%h want ffffffff/fffffffe", hi_out, lo_out);
        end
        m_hi = 32'hFFFF_FFFF; m_lo = 32'hFFFF_FFFE;
    endtask

    task automatic test_multu;
        int c; bit hd;
        do_op(MD_MULTU, 32'hFFFF_FFFF, 32'd2, c, hd);
        checks++;
        if (hi_out !== 32'h0000_0001 || lo_out !== 32'hFFFF_FFFE || c !== MULT_N) begin
            errors++; $display("FAIL multu: hi=%h lo=%h busy=%0d want 00000001/fffffffe/%0d", hi_out, lo_out, c, MULT_N);
        end
        m_hi = 32'h1; m_lo = 32'hFFFF_FFFE;
    endtask

    task automatic test_div;
        int c; bit hd;
        do_op(MD_DIV, 32'hFFFF_FFF9, 32'd2, c, hd);
        checks++;
        if (c !== DIV_N) begin errors++; $display("FAIL div_busy: got %0d want %0d", c, DIV_N); end
        checks++;
        if (lo_out !== 32'hFFFF_FFFD || hi_out !== 32'hFFFF_FFFF) begin
            errors++; $display("FAIL div_result: hi=%h lo=%h want ffffffff/fffffffd", hi_out, lo_out);
        end
        do_op(MD_DIV, 32'h8000_0000, 32'hFFFF_FFFF, c, hd);
        checks++;
        if (lo_out !== 32'h8000_0000 || hi_out !== 32'h0) begin
            errors++; $display("FAIL div_overflow: hi=%h lo=%h want 00000000/80000000", hi_out, lo_out);
        end
        m_hi = 32'h0; m_lo = 32'h8000_0000;
    endtask

    task automatic test_divu_zero;
        int c; bit hd;
        set_hilo(32'h1357_9BDF, 32'h2468_ACE0);
        do_op(MD_DIVU, 32'd7, 32'd0, c, hd);
        checks++;
        if (c !== DIV_N) begin errors++; $display("FAIL divz_busy: got %0d want %0d", c, DIV_N); end
        checks++;
        if (hi_out !== 32'h1357_9BDF || lo_out !== 32'h2468_ACE0) begin
            errors++; $display("FAIL divz_hilo: hi=%h lo=%h want 13579bdf/2468ace0", hi_out, lo_out);
        end
    endtask

    task automatic test_req;
        logic [31:0] h0;
        h0 = hi_out;
        start = 1'b1; md_op = MD_MTHI; rs_val = 32'h1234; req = 1'b1;
        @(posedge clk); #1;
        checks++;
        if (hi_out !== h0) begin errors++; $display("FAIL req_block: hi=%h want %h", hi_out, h0); end
        req = 1'b0;
        @(posedge clk); #1;
        start = 1'b0;
        checks++;
        if (hi_out !== 32'h1234) begin errors++; $display("FAIL mthi: hi=%h want 00001234", hi_out); end
        m_hi = 32'h1234;
        md_op = MD_MFHI; #1;
        checks++;
        if (md_out !== 32'h1234) begin errors++; $display("FAIL mfhi: md_out=%h want 00001234", md_out); end
        md_op = MD_NONE;
    endtask

    // req arriving while a divide runs must not abort it.
    task automatic test_req_running;
        int c;
        start = 1'b1; md_op = MD_DIVU; rs_val = 32'd100; rt_val = 32'd7;
        @(posedge clk); #1;
        start = 1'b0; md_op = MD_NONE; c = 1;
        req = 1'b1;
        @(posedge clk); #1;
        req = 1'b0;
        while (busy && c < 200) begin c++; @(posedge clk); #1; end
        checks++;
        if (c !== DIV_N || hi_out !== 32'd2 || lo_out !== 32'd14) begin
            errors++; $display("FAIL req_running: busy=%0d hi=%h lo=%h want %0d/2/14", c, hi_out, lo_out, DIV_N);
        end
        m_hi = 32'd2; m_lo = 32'd14;
    endtask

    task automatic test_reset_mid;
        start = 1'b1; md_op = MD_MULT; rs_val = 32'd9; rt_val = 32'd9;
        @(posedge clk); #1;
        start = 1'b0; md_op = MD_NONE;
        repeat (2) begin @(posedge clk); #1; end
        reset = 1'b1;
        @(posedge clk); #1;
        reset = 1'b0;
        checks++;
        if (busy !== 1'b0 || hi_out !== 32'd0 || lo_out !== 32'd0) begin
            errors++; $display("FAIL reset_mid: busy=%b hi=%h lo=%h want 0/0/0", busy, hi_out, lo_out);
        end
        repeat (6) begin @(posedge clk); #1; end
        checks++;
        if (hi_out !== 32'd0 || lo_out !== 32'd0) begin
            errors++; $display("FAIL reset_nocommit: hi=%h lo=%h want 0/0", hi_out, lo_out);
        end
        m_hi = '0; m_lo = '0;
    endtask

    task automatic test_start_busy;
        int c; bit hd;
        logic [31:0] h0, l0;
        h0 = hi_out; l0 = lo_out;
        start = 1'b1; md_op = MD_MULTU; rs_val = 32'd3; rt_val = 32'd4;
        @(posedge clk); #1;
        c = 1; hd = 1'b1;
        md_op = MD_MTLO; rs_val = 32'hDEAD_BEEF;
        @(posedge clk); #1;
        c++;
        if (hi_out !== h0 || lo_out !== l0) hd = 1'b0;
        md_op = MD_DIV; rs_val = 32'd50; rt_val = 32'd5;
        @(posedge clk); #1;
        start = 1'b0; md_op = MD_NONE;
        while (busy && c < 200) begin
            c++;
            if (hi_out !== h0 || lo_out !== l0) hd = 1'b0;
            @(posedge clk); #1;
        end
        checks++;
        if (c !== MULT_N || !hd) begin
            errors++; $display("FAIL start_busy_cnt: busy=%0d held=%0d want %0d/1", c, hd, MULT_N);
        end
        checks++;
        if (hi_out !== 32'd0 || lo_out !== 32'd12) begin
            errors++; $display("FAIL start_busy_result: hi=%h lo=%h want 0/0000000c", hi_out, lo_out);
        end
        m_hi = 32'd0; m_lo = 32'd12;
    endtask

    task automatic test_madd;
        int c; bit hd;
`ifdef MDU_MADD_EN
        set_hilo(32'd0, 32'hFFFF_FFFF);
        do_op(MD_MADDU, 32'd1, 32'd1, c, hd);
        checks++;
        if (hi_out !== 32'd1 || lo_out !== 32'd0 || c !== MULT_N) begin
            errors++; $display("FAIL maddu: hi=%h lo=%h busy=%0d want 1/0/%0d", hi_out, lo_out, c, MULT_N);
        end
        model(MD_MADDU, 32'd1, 32'd1, m_hi, m_lo);
`else
        set_hilo(32'h0000_00AB, 32'h0000_00CD);
        do_op(MD_MADD, 32'd5, 32'd6, c, hd);
        checks++;
        if (hi_out !== 32'hAB || lo_out !== 32'hCD || c !== 0) begin
            errors++; $display("FAIL madd_disabled: hi=%h lo=%h busy=%0d want ab/cd/0", hi_out, lo_out, c);
        end
`endif
    endtask

    task automatic test_random;
        int c; bit hd;
        md_op_t op;
        logic [31:0] a, b;
        logic [31:0] edges [4];
        edges[0] = 32'h8000_0000; edges[1] = 32'hFFFF_FFFF;
        edges[2] = 32'h7FFF_FFFF; edges[3] = 32'h0000_0001;
        for (int i = 0; i < 40; i++) begin
            case ($urandom_range(0, 7))
                0: op = MD_MULT;  1: op = MD_MULTU;
                2: op = MD_DIV;   3: op = MD_DIVU;
                4: op = MD_MTHI;  5: op = MD_MTLO;
`ifdef MDU_MADD_EN
                6: op = ($urandom_range(0, 1) == 0) ? MD_MADD : MD_MSUBU;
`else
                6: op = MD_MFLO;
`endif
                default: op = MD_NONE;
            endcase
            a = ($urandom_range(0, 3) == 0) ? edges[$urandom_range(0, 3)] : $urandom;
            b = ($urandom_range(0, 3) == 0) ? edges[$urandom_range(0, 3)] : $urandom;
            if ($urandom_range(0, 7) == 0) b = 32'd0;
            do_op(op, a, b, c, hd);
            model(op, a, b, m_hi, m_lo);
            checks++;
            if (hi_out !== m_hi || lo_out !== m_lo || c !== exp_busy(op) || !hd) begin
                errors++;
                $display("FAIL random[%0d] op=%0d a=%h b=%h: hi=%h lo=%h busy=%0d held=%0d want %h/%h/%0d/1",
                         i, op, a, b, hi_out, lo_out, c, hd, m_hi, m_lo, exp_busy(op));
            end
            md_op = ($urandom_range(0, 1) == 0) ? MD_MFHI : MD_MFLO; #1;
            checks++;
            if (md_out !== ((md_op == MD_MFHI) ? m_hi : m_lo)) begin
                errors++; $display("FAIL random_mf[%0d]: md_out=%h hi=%h lo=%h", i, md_out, m_hi, m_lo);
            end
            md_op = MD_NONE;
        end
    endtask

    initial begin
        test_reset();
        test_mult();
        test_multu();
        test_div();
        test_divu_zero();
        test_req();
        test_req_running();
        test_reset_mid();
        test_start_busy();
        test_madd();
        test_random();
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
